// File: rtl/ball_serve_ctrl_if.sv
// ball_serve_ctrl_if: groups the serve request, the random-sample buses and the
// launch handshake of the ball serve controller.
//   serve_req, side        game FSM -> controller
//   rand_pos, rand_power   RNG (already synchronised) -> controller
//   launch_valid/ready     controller <-> ball engine handshake
//   ball_y, ball_vx/vy     launch payload
//   busy, fallback         status
// modport master: the serve controller; modport slave: its environment.
interface ball_serve_ctrl_if;
    logic       serve_req;
    logic       side;
    logic [8:0] rand_pos;
    logic [1:0] rand_power;
    logic       launch_ready;
    logic       launch_valid;
    logic [8:0] ball_y;
    logic [3:0] ball_vx;
    logic [3:0] ball_vy;
    logic       busy;
    logic       fallback;

    modport master (
        input  serve_req, side, rand_pos, rand_power, launch_ready,
        output launch_valid, ball_y, ball_vx, ball_vy, busy, fallback
    );

    modport slave (
        output serve_req, side, rand_pos, rand_power, launch_ready,
        input  launch_valid, ball_y, ball_vx, ball_vy, busy, fallback
    );
endinterface

// File: rtl/ball_serve_ctrl.sv
// ball_serve_ctrl: consumer end of the Pong RNG path. On serve_req it samples
// {rand_pos, rand_power} until the value holds for STABLE_CNT consecutive
// samples (or TIMEOUT SAMPLE cycles pass), maps it to a clamped start row and
// signed velocities, offers it on a valid/ready launch handshake, then holds
// off further serves for COOLDOWN_CYC cycles.
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    ball_serve_ctrl_if.master (request, RNG buses, launch handshake,
//          busy/fallback status); all outputs are registered.
module ball_serve_ctrl #(
    parameter int POS_MIN      = 91,
    parameter int POS_MAX      = 390,
    parameter int SPEED_BASE   = 1,
    parameter int STABLE_CNT   = 2,
    parameter int TIMEOUT      = 16,
    parameter int COOLDOWN_CYC = 60
) (
    input  logic               clk,
    input  logic               rst_n,
    ball_serve_ctrl_if.master  bus
);
    localparam int SW = $clog2(STABLE_CNT + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int CW = $clog2(COOLDOWN_CYC + 1);

    typedef enum logic [1:0] {IDLE, SAMPLE, LAUNCH, COOLDOWN} state_t;

    state_t          state, state_d;
    logic [10:0]     prev, prev_d, cur;
    logic            side_q, side_d, side_sel;
    logic [SW-1:0]   stab_cnt, stab_d;
    logic [TW-1:0]   tmo_cnt, tmo_d;
    logic [CW-1:0]   cd_cnt, cd_d;
    logic            lv_q, lv_d, busy_q, busy_d, fb_q, fb_d;
    logic [8:0]      y_q, y_d, pos, y_map;
    logic [3:0]      vx_q, vx_d, vy_q, vy_d;
    logic [3:0]      vx_mag, vy_mag, vx_map, vy_map;
    logic            accept, forced, same, hs;

    assign cur  = {bus.rand_pos, bus.rand_power};
    assign same = (cur == prev);
    assign hs   = lv_q & bus.launch_ready;

    // In IDLE (STABLE_CNT==1 path) the side has not been latched yet.
    assign side_sel = (state == IDLE) ? bus.side : side_q;

    // Sample -> launch payload mapping.
    assign pos    = cur[10:2];
    assign y_map  = (pos < 9'(POS_MIN)) ? 9'(POS_MIN) :
                    (pos > 9'(POS_MAX)) ? 9'(POS_MAX) : pos;
    assign vx_mag = 4'(SPEED_BASE) + {2'b00, cur[1:0]};
    assign vy_mag = 4'd1 + {3'b000, cur[1]};
    assign vx_map = side_sel ? vx_mag : (4'd0 - vx_mag);
    assign vy_map = pos[0]   ? (4'd0 - vy_mag) : vy_mag;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state;
        accept  = 1'b0;
        forced  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.serve_req) begin
                    if (STABLE_CNT == 1) begin
                        accept  = 1'b1;
                        state_d = LAUNCH;
                    end else begin
                        state_d = SAMPLE;
                    end
                end
            end
            SAMPLE: begin
                if (same && (stab_cnt + SW'(1)) == SW'(STABLE_CNT)) begin
                    accept  = 1'b1;
                    state_d = LAUNCH;
                end else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
                    accept  = 1'b1;
                    forced  = 1'b1;
                    state_d = LAUNCH;
                end
            end
            LAUNCH:   if (hs) state_d = COOLDOWN;
            COOLDOWN: if (cd_cnt == '0) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Output / datapath next values (registered below)
    always_comb begin
        prev_d = prev;
        side_d = side_q;
        stab_d = stab_cnt;
        tmo_d  = tmo_cnt;
        cd_d   = cd_cnt;
        lv_d   = lv_q;
        fb_d   = fb_q;
        y_d    = y_q;
        vx_d   = vx_q;
        vy_d   = vy_q;
        busy_d = (state_d != IDLE);

        case (state)
            IDLE: begin
                if (bus.serve_req) begin
                    side_d = bus.side;
                    prev_d = cur;
                    stab_d = SW'(1);
                    tmo_d  = '0;
                end
            end
            SAMPLE: begin
                if (same) begin
                    stab_d = stab_cnt + SW'(1);
                end else begin
                    prev_d = cur;
                    stab_d = SW'(1);
                end
                if (!accept) tmo_d = tmo_cnt + TW'(1);
            end
            LAUNCH: begin
                if (hs) begin
                    lv_d = 1'b0;
                    cd_d = CW'(COOLDOWN_CYC - 1);
                end
            end
            COOLDOWN: begin
                if (cd_cnt != '0) cd_d = cd_cnt - CW'(1);
            end
            default: ;
        endcase

        if (accept) begin
            lv_d = 1'b1;
            fb_d = forced;
            y_d  = y_map;
            vx_d = vx_map;
            vy_d = vy_map;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev     <= '0;
            side_q   <= 1'b0;
            stab_cnt <= '0;
            tmo_cnt  <= '0;
            cd_cnt   <= '0;
            lv_q     <= 1'b0;
            busy_q   <= 1'b0;
            fb_q     <= 1'b0;
            y_q      <= '0;
            vx_q     <= '0;
            vy_q     <= '0;
        end else begin
            prev     <= prev_d;
            side_q   <= side_d;
            stab_cnt <= stab_d;
            tmo_cnt  <= tmo_d;
            cd_cnt   <= cd_d;
            lv_q     <= lv_d;
            busy_q   <= busy_d;
            fb_q     <= fb_d;
            y_q      <= y_d;
            vx_q     <= vx_d;
            vy_q     <= vy_d;
        end
    end

    assign bus.launch_valid = lv_q;
    assign bus.busy         = busy_q;
    assign bus.fallback     = fb_q;
    assign bus.ball_y       = y_q;
    assign bus.ball_vx      = vx_q;
    assign bus.ball_vy      = vy_q;
endmodule

// File: tb/tb_ball_serve_ctrl.sv
// tb_ball_serve_ctrl: directed stimulus with a launch scoreboard. Stimulus
// pushes the hand-computed launch payload when it issues a serve; a monitor
// pops and compares on every launch handshake.
module tb_ball_serve_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ball_serve_ctrl_if bus ();

    ball_serve_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    typedef struct packed {
        logic [8:0] y;
        logic [3:0] vx;
        logic [3:0] vy;
        logic       fb;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    function automatic exp_t mk(input logic [8:0] y, input logic [3:0] vx,
                                input logic [3:0] vy, input logic fb);
        exp_t e;
        e.y = y; e.vx = vx; e.vy = vy; e.fb = fb;
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues a one-cycle serve; returns one cycle later (cycle 1).
    task automatic serve(input logic s, input logic [8:0] p, input logic [1:0] w,
                         input exp_t e, input bit push);
        bus.side       = s;
        bus.rand_pos   = p;
        bus.rand_power = w;
        bus.serve_req  = 1'b1;
        if (push) sb.push_back(e);
        tick();
        bus.serve_req = 1'b0;
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!bus.launch_valid && n < 40) begin tick(); n++; end
        if (!bus.launch_valid) begin
            checks++; errors++;
            $display("FAIL wait_valid: launch_valid still 0 after %0d cycles", n);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (bus.busy && n < 100) begin tick(); n++; end
        if (bus.busy) begin
            checks++; errors++;
            $display("FAIL wait_idle: busy still 1 after %0d cycles", n);
        end
    endtask

    task automatic run_serve(input logic s, input logic [8:0] p, input logic [1:0] w, input exp_t e);
        serve(s, p, w, e, 1'b1);
        wait_valid();
        tick();
        wait_idle();
    endtask

    // Monitor: compare payload on every handshake.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && bus.launch_valid && bus.launch_ready) begin
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_launch: y=%0d vx=%0h vy=%0h expected none",
                             bus.ball_y, bus.ball_vx, bus.ball_vy);
                end else begin
                    e = sb.pop_front();
                    chk("ball_y",   bus.ball_y,   e.y);
                    chk("ball_vx",  bus.ball_vx,  e.vx);
                    chk("ball_vy",  bus.ball_vy,  e.vy);
                    chk("fallback", bus.fallback, e.fb);
                end
            end
        end
    end

    logic        t_s[6];
    logic [8:0]  t_p[6];
    logic [1:0]  t_w[6];
    exp_t        t_e[6];

    initial begin
        bus.serve_req = 1'b0; bus.side = 1'b0; bus.rand_pos = '0; bus.rand_power = '0;
        bus.launch_ready = 1'b1;

        // Clamp / sign table
        t_s[0] = 0; t_p[0] = 50;  t_w[0] = 0; t_e[0] = mk(91,  4'hF, 4'h1, 0);
        t_s[1] = 0; t_p[1] = 401; t_w[1] = 1; t_e[1] = mk(390, 4'hE, 4'hF, 0);
        t_s[2] = 1; t_p[2] = 91;  t_w[2] = 3; t_e[2] = mk(91,  4'h4, 4'hE, 0);
        t_s[3] = 1; t_p[3] = 390; t_w[3] = 0; t_e[3] = mk(390, 4'h1, 4'h1, 0);
        t_s[4] = 1; t_p[4] = 90;  t_w[4] = 2; t_e[4] = mk(91,  4'h3, 4'h2, 0);
        t_s[5] = 0; t_p[5] = 511; t_w[5] = 3; t_e[5] = mk(390, 4'hC, 4'hE, 0);

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", bus.launch_valid, 0);
        chk("rst_busy",  bus.busy, 0);
        chk("rst_fb",    bus.fallback, 0);
        chk("rst_y",     bus.ball_y, 0);
        chk("rst_vx",    bus.ball_vx, 0);
        chk("rst_vy",    bus.ball_vy, 0);
        rst_n = 1'b1;
        tick();

        // Basic serve and latency
        serve(1, 200, 2, mk(200, 4'h3, 4'h2, 0), 1'b1);
        chk("t1_busy_c1",  bus.busy, 1);
        chk("t1_valid_c1", bus.launch_valid, 0);
        tick();
        chk("t1_valid_c2", bus.launch_valid, 1);
        tick();
        chk("t1_valid_c3", bus.launch_valid, 0);
        chk("t1_busy_c3",  bus.busy, 1);
        wait_idle();

        // Clamp low, then cooldown behaviour around it
        serve(0, 50, 0, mk(91, 4'hF, 4'h1, 0), 1'b1);
        wait_valid();
        tick();                       // cycle h+1 after handshake in cycle h
        repeat (9) tick();            // h+10
        bus.serve_req = 1'b1;
        tick();
        bus.serve_req = 1'b0;         // h+11
        chk("cd_busy_ignored", bus.busy, 1);
        chk("cd_valid_ignored", bus.launch_valid, 0);
        repeat (49) tick();           // h+60: last COOLDOWN cycle
        chk("cd_busy_c60", bus.busy, 1);
        bus.serve_req = 1'b1;         // lands on the COOLDOWN->IDLE edge
        tick();
        bus.serve_req = 1'b0;         // h+61
        chk("cd_idle_c61", bus.busy, 0);
        repeat (3) tick();
        chk("cd_edge_req_ignored_busy", bus.busy, 0);
        chk("cd_edge_req_ignored_valid", bus.launch_valid, 0);

        // Clamp / sign table
        for (int i = 0; i < 6; i++) run_serve(t_s[i], t_p[i], t_w[i], t_e[i]);

        // Unstable inputs: forced acceptance after 16 SAMPLE cycles
        serve(1, 100, 1, mk(100, 4'h2, 4'h1, 1), 1'b1);
        for (int k = 1; k <= 16; k++) begin
            bus.rand_pos = (k % 2 == 1) ? 9'd101 : 9'd100;
            chk("t3_no_early_accept", bus.launch_valid, 0);
            tick();
        end
        chk("t3_valid_c17", bus.launch_valid, 1);
        chk("t3_fallback",  bus.fallback, 1);
        tick();
        wait_idle();

        // Backpressure
        bus.launch_ready = 1'b0;
        serve(0, 300, 3, mk(300, 4'hC, 4'h2, 0), 1'b1);
        wait_valid();
        for (int i = 0; i < 5; i++) begin
            bus.rand_pos = 9'($urandom_range(0, 511));
            bus.rand_power = 2'($urandom_range(0, 3));
            chk("bp_valid", bus.launch_valid, 1);
            chk("bp_y",  bus.ball_y, 300);
            chk("bp_vx", bus.ball_vx, 4'hC);
            chk("bp_vy", bus.ball_vy, 4'h2);
            chk("bp_fb", bus.fallback, 0);
            tick();
        end
        bus.launch_ready = 1'b1;
        chk("bp_valid_at_ready", bus.launch_valid, 1);
        tick();
        chk("bp_valid_drop", bus.launch_valid, 0);
        wait_idle();

        // Asynchronous reset mid-LAUNCH
        bus.launch_ready = 1'b0;
        serve(1, 150, 0, mk(150, 4'h1, 4'h1, 0), 1'b0);
        wait_valid();
        tick();
        rst_n = 1'b0;
        #1;
        chk("ar_valid", bus.launch_valid, 0);
        chk("ar_busy",  bus.busy, 0);
        chk("ar_y",     bus.ball_y, 0);
        chk("ar_vx",    bus.ball_vx, 0);
        chk("ar_vy",    bus.ball_vy, 0);
        chk("ar_fb",    bus.fallback, 0);
        tick();
        rst_n = 1'b1;
        bus.launch_ready = 1'b1;
        tick();
        chk("ar_idle_busy", bus.busy, 0);
        run_serve(1, 391, 2, mk(390, 4'h3, 4'hE, 0));

        repeat (2) tick();
        chk("sb_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
